// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - multi-cycle EX-stage ALU; define ALU_MULT_EN to build the MULTU shift-add multiplier
module alu_seq #(
  parameter int WORD_SIZE = 32,
  parameter int SHAMT_W   = $clog2(WORD_SIZE)
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [WORD_SIZE-1:0] input_a,
  input  logic [WORD_SIZE-1:0] input_b,
  input  logic [3:0]           control,
  output logic                 busy,
  output logic                 finished,
  output logic [WORD_SIZE-1:0] result,
  output logic [WORD_SIZE-1:0] result_hi,
  output logic                 zero,
  output logic                 cout,
  output logic                 err_overflow,
  output logic                 err_invalid_control
);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_ADDU  = 4'b0011;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_SLTU  = 4'b1000;
  localparam logic [3:0] OP_SLL   = 4'b1001;
  localparam logic [3:0] OP_SRL   = 4'b1010;
  localparam logic [3:0] OP_SRA   = 4'b1011;
  localparam logic [3:0] OP_NOR   = 4'b1100;
`ifdef ALU_MULT_EN
  localparam logic [3:0] OP_MULTU = 4'b1101;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
`ifdef ALU_MULT_EN
    MULT  = 2'd3,
`endif
    DONE  = 2'd2
  } state_t;

  state_t state, next_state;

  // Operands latched at acceptance; later input changes are invisible to the op.
  logic [WORD_SIZE-1:0] a_q;
  logic [WORD_SIZE-1:0] b_q;
  logic [3:0]           op_q;

  // Iterative shifter working value and remaining-step counter.
  logic [WORD_SIZE-1:0] sh_val;
  logic [WORD_SIZE-1:0] sh_next;
  logic [SHAMT_W-1:0]   sh_cnt;

`ifdef ALU_MULT_EN
  // Shift-add multiplier: prod_lo starts as the multiplier and is consumed LSB first
  // while product bits shift in from the top.
  logic [WORD_SIZE-1:0] prod_hi;
  logic [WORD_SIZE-1:0] prod_lo;
  logic [SHAMT_W-1:0]   mul_cnt;
  logic [WORD_SIZE:0]   mul_sum;
  logic [WORD_SIZE-1:0] hi_nxt;
`endif

  logic                 accept;
  logic                 start_shift;
  logic                 is_sub;
  logic [WORD_SIZE-1:0] b_eff;
  logic [WORD_SIZE:0]   sum;
  logic [WORD_SIZE-1:0] res_nxt;
  logic                 c_nxt;
  logic                 v_nxt;
  logic                 inv_nxt;
  logic                 zero_nxt;

  assign accept = (state == IDLE) && start;

  // A zero shift amount needs no iterations, so it bypasses SHIFT entirely.
  assign start_shift = ((control == OP_SLL) || (control == OP_SRL) || (control == OP_SRA)) &&
                       (input_b[SHAMT_W-1:0] != '0);

  assign busy = (state != IDLE);

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state selection; start is only honoured in IDLE.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (start_shift) next_state = SHIFT;
`ifdef ALU_MULT_EN
          else if (control == OP_MULTU) next_state = MULT;
`endif
          else next_state = DONE;
        end
      end
      SHIFT: begin
        if (sh_cnt == SHAMT_W'(1)) next_state = DONE;
      end
`ifdef ALU_MULT_EN
      MULT: begin
        if (mul_cnt == '0) next_state = DONE;
      end
`endif
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // One-bit shift step selected by the latched opcode; SRA replicates the sign bit.
  always_comb begin
    sh_next = sh_val;
    case (op_q)
      OP_SLL:  sh_next = {sh_val[WORD_SIZE-2:0], 1'b0};
      OP_SRL:  sh_next = {1'b0, sh_val[WORD_SIZE-1:1]};
      OP_SRA:  sh_next = {sh_val[WORD_SIZE-1], sh_val[WORD_SIZE-1:1]};
      default: sh_next = sh_val;
    endcase
  end

`ifdef ALU_MULT_EN
  assign mul_sum = {1'b0, prod_hi} + (prod_lo[0] ? {1'b0, a_q} : '0);
`endif

  // Operand latch plus the shift and multiply iteration registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      sh_val  <= '0;
      sh_cnt  <= '0;
`ifdef ALU_MULT_EN
      prod_hi <= '0;
      prod_lo <= '0;
      mul_cnt <= '0;
`endif
    end else if (accept) begin
      a_q     <= input_a;
      b_q     <= input_b;
      op_q    <= control;
      sh_val  <= input_a;
      sh_cnt  <= input_b[SHAMT_W-1:0];
`ifdef ALU_MULT_EN
      prod_hi <= '0;
      prod_lo <= input_b;
      mul_cnt <= SHAMT_W'(WORD_SIZE - 1);
`endif
    end else if (state == SHIFT) begin
      sh_val <= sh_next;
      sh_cnt <= sh_cnt - SHAMT_W'(1);
    end
`ifdef ALU_MULT_EN
    else if (state == MULT) begin
      prod_hi <= mul_sum[WORD_SIZE:1];
      prod_lo <= {mul_sum[0], prod_lo[WORD_SIZE-1:1]};
      mul_cnt <= mul_cnt - SHAMT_W'(1);
    end
`endif
  end

  // SUB reuses the adder as a + ~b + 1 so cout is the no-borrow carry.
  assign is_sub = (op_q == OP_SUB);
  assign b_eff  = is_sub ? ~b_q : b_q;
  assign sum    = {1'b0, a_q} + {1'b0, b_eff} + {{WORD_SIZE{1'b0}}, is_sub};

  // Final result and flags for the latched op, consumed only in DONE.
  always_comb begin
    res_nxt = '0;
    c_nxt   = 1'b0;
    v_nxt   = 1'b0;
    inv_nxt = 1'b0;
`ifdef ALU_MULT_EN
    hi_nxt  = '0;
`endif
    case (op_q)
      OP_AND:  res_nxt = a_q & b_q;
      OP_OR:   res_nxt = a_q | b_q;
      OP_NOR:  res_nxt = ~(a_q | b_q);
      OP_ADD, OP_SUB: begin
        res_nxt = sum[WORD_SIZE-1:0];
        c_nxt   = sum[WORD_SIZE];
        v_nxt   = (a_q[WORD_SIZE-1] == b_eff[WORD_SIZE-1]) &&
                  (sum[WORD_SIZE-1] != a_q[WORD_SIZE-1]);
      end
      OP_ADDU: begin
        res_nxt = sum[WORD_SIZE-1:0];
        c_nxt   = sum[WORD_SIZE];
        v_nxt   = sum[WORD_SIZE];
      end
      OP_SLT:  res_nxt = {{(WORD_SIZE-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      OP_SLTU: res_nxt = {{(WORD_SIZE-1){1'b0}}, (a_q < b_q)};
      OP_SLL, OP_SRL, OP_SRA: res_nxt = sh_val;
`ifdef ALU_MULT_EN
      OP_MULTU: begin
        res_nxt = prod_lo;
        hi_nxt  = prod_hi;
      end
`endif
      default: inv_nxt = 1'b1;
    endcase
  end

`ifdef ALU_MULT_EN
  assign zero_nxt = ~|{hi_nxt, res_nxt};
`else
  assign zero_nxt = ~|res_nxt;
`endif

  // Output registers update only in DONE and hold until the next completion.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      finished            <= 1'b0;
      result              <= '0;
      zero                <= 1'b0;
      cout                <= 1'b0;
      err_overflow        <= 1'b0;
      err_invalid_control <= 1'b0;
    end else begin
      finished <= (state == DONE);
      if (state == DONE) begin
        result              <= res_nxt;
        zero                <= zero_nxt;
        cout                <= c_nxt;
        err_overflow        <= v_nxt;
        err_invalid_control <= inv_nxt;
      end
    end
  end

`ifdef ALU_MULT_EN
  // High product word, registered alongside the low word.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      result_hi <= '0;
    end else if (state == DONE) begin
      result_hi <= hi_nxt;
    end
  end
`else
  assign result_hi = '0;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed self-checking bench for alu_seq with a behavioural reference model
`timescale 1ns/1ps
module tb_alu_seq;
  localparam int W = 32;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic         clock   = 1'b0;
  logic         reset_n = 1'b0;
  logic         start   = 1'b0;
  logic [W-1:0] input_a = '0;
  logic [W-1:0] input_b = '0;
  logic [3:0]   control = '0;
  logic         busy, finished, zero, cout, err_overflow, err_invalid_control;
  logic [W-1:0] result, result_hi;

  int errors = 0;
  int checks = 0;

  alu_seq #(.WORD_SIZE(W)) dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .input_a(input_a), .input_b(input_b), .control(control),
    .busy(busy), .finished(finished), .result(result), .result_hi(result_hi),
    .zero(zero), .cout(cout), .err_overflow(err_overflow),
    .err_invalid_control(err_invalid_control)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic z, c, v, inv;
  } outs_t;

  function automatic outs_t model_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    outs_t o;
    longint sa, sb, sres;
    logic [63:0] ua, ub, ures;
    int sh;
    o = '0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    sh = int'(b[4:0]);
    case (op)
      4'h0: o.lo = a & b;
      4'h1: o.lo = a | b;
      4'h2: begin
        ures = ua + ub; o.lo = ures[31:0]; o.c = ures[32];
        sres = sa + sb; o.v = (sres > SMAX) || (sres < SMIN);
      end
      4'h3: begin
        ures = ua + ub; o.lo = ures[31:0]; o.c = ures[32]; o.v = ures[32];
      end
      4'h6: begin
        o.lo = a - b; o.c = (a >= b);
        sres = sa - sb; o.v = (sres > SMAX) || (sres < SMIN);
      end
      4'h7: o.lo = (sa < sb) ? 32'd1 : 32'd0;
      4'h8: o.lo = (a < b) ? 32'd1 : 32'd0;
      4'h9: o.lo = a << sh;
      4'hA: o.lo = a >> sh;
      4'hB: o.lo = $signed(a) >>> sh;
      4'hC: o.lo = ~(a | b);
`ifdef ALU_MULT_EN
      4'hD: begin
        ures = ua * ub; o.hi = ures[63:32]; o.lo = ures[31:0];
      end
`endif
      default: o.inv = 1'b1;
    endcase
    o.z = ({o.hi, o.lo} == 64'd0);
    return o;
  endfunction

  function automatic int model_lat(input logic [3:0] op, input logic [W-1:0] b);
    if (op == 4'h9 || op == 4'hA || op == 4'hB) return int'(b[4:0]) + 1;
`ifdef ALU_MULT_EN
    if (op == 4'hD) return W + 1;
`endif
    return 1;
  endfunction

  // Reference: remembers the pending answer and counts down its latency.
  outs_t m_out  = '0;
  outs_t m_pend = '0;
  int    m_left = 0;
  logic  m_fin  = 1'b0;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_out = '0; m_pend = '0; m_left = 0; m_fin = 1'b0;
    end else begin
      m_fin = 1'b0;
      if (m_left == 0) begin
        if (start) begin
          m_left = model_lat(control, input_b);
          m_pend = model_op(control, input_a, input_b);
        end
      end else begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_out = m_pend;
          m_fin = 1'b1;
        end
      end
    end
  end

  always @(negedge clock) begin
    checks++;
    if ({busy, finished, result_hi, result, zero, cout, err_overflow, err_invalid_control} !==
        {(m_left != 0), m_fin, m_out}) begin
      errors++;
      $display("FAIL cycle_model t=%0t got busy=%b fin=%b hi=%h res=%h zcvi=%b%b%b%b required busy=%b fin=%b hi=%h res=%h zcvi=%b%b%b%b",
               $time, busy, finished, result_hi, result, zero, cout, err_overflow, err_invalid_control,
               (m_left != 0), m_fin, m_out.hi, m_out.lo, m_out.z, m_out.c, m_out.v, m_out.inv);
    end
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Issues one op, scrambles the operands while busy, optionally pokes start mid-op.
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int poke_at, output int lat, output int busy_n);
    @(negedge clock); #1;
    start = 1'b1; control = op; input_a = a; input_b = b;
    @(posedge clock); #1;
    start = 1'b0; control = 4'h0; input_a = ~a; input_b = ~b;
    lat = 0;
    busy_n = busy ? 1 : 0;
    while (lat < 100) begin
      @(posedge clock); #1;
      lat++;
      start = 1'b0;
      if (finished) break;
      if (busy) busy_n++;
      if (poke_at == lat) begin
        start = 1'b1; control = 4'h2; input_a = 32'd3; input_b = 32'd3;
      end
    end
  endtask

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic [3:0]   flags;
    int           lat;
    string        name;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int lat, busy_n;
    outs_t mo;

    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, busy_n;
    outs_t mo;

    // flags are {zero, cout, err_overflow, err_invalid_control}
    vecs.push_back('{4'h2, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'h0, 4'b0010, 1,  "add_ovf"});
    vecs.push_back('{4'h2, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h0, 4'b1100, 1,  "add_carry"});
    vecs.push_back('{4'h6, 32'h00000000, 32'hFFFFFFFF, 32'h00000001, 32'h0, 4'b0000, 1,  "sub_0_m1"});
    vecs.push_back('{4'h6, 32'h00000005, 32'h00000005, 32'h00000000, 32'h0, 4'b1100, 1,  "sub_eq"});
    vecs.push_back('{4'h6, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 32'h0, 4'b0110, 1,  "sub_ovf"});
    vecs.push_back('{4'h3, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h0, 4'b1110, 1,  "addu_wrap"});
    vecs.push_back('{4'h7, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 32'h0, 4'b0000, 1,  "slt"});
    vecs.push_back('{4'h8, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h0, 4'b1000, 1,  "sltu"});
    vecs.push_back('{4'hB, 32'h80000000, 32'h00000004, 32'hF8000000, 32'h0, 4'b0000, 5,  "sra4"});
    vecs.push_back('{4'h9, 32'h00001234, 32'h00000000, 32'h00001234, 32'h0, 4'b0000, 1,  "sll0"});
    vecs.push_back('{4'h9, 32'h00000001, 32'hFFFFFFE3, 32'h00000008, 32'h0, 4'b0000, 4,  "sll3"});
    vecs.push_back('{4'hA, 32'h80000000, 32'h0000001F, 32'h00000001, 32'h0, 4'b0000, 32, "srl31"});
    vecs.push_back('{4'h0, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 32'h0, 4'b0000, 1,  "and"});
    vecs.push_back('{4'h1, 32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFF0F0, 32'h0, 4'b0000, 1,  "or"});
    vecs.push_back('{4'hC, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32'h0, 4'b0000, 1,  "nor"});
    vecs.push_back('{4'hF, 32'h12345678, 32'h00000009, 32'h00000000, 32'h0, 4'b1001, 1,  "invalid_f"});
`ifdef ALU_MULT_EN
    vecs.push_back('{4'hD, 32'h0000FFFF, 32'h00010001, 32'hFFFFFFFF, 32'h0, 4'b0000, 33, "multu_small"});
`else
    vecs.push_back('{4'hD, 32'hFFFFFFFF, 32'h00000002, 32'h00000000, 32'h0, 4'b1001, 1,  "invalid_d"});
`endif

    repeat (2) @(posedge clock);
    #1;
    check("reset_busy",     W'(busy), 32'd0);
    check("reset_finished", W'(finished), 32'd0);
    check("reset_result",   result, 32'd0);
    check("reset_hi",       result_hi, 32'd0);
    check("reset_flags",    W'({zero, cout, err_overflow, err_invalid_control}), 32'd0);
    @(negedge clock); #1;
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      mo = model_op(vecs[i].op, vecs[i].a, vecs[i].b);
      check({"model_", vecs[i].name}, mo.lo, vecs[i].lo);
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, -1, lat, busy_n);
      check({vecs[i].name, "_latency"}, W'(lat), W'(vecs[i].lat));
      check({vecs[i].name, "_busy_cycles"}, W'(busy_n), W'(vecs[i].lat));
      check({vecs[i].name, "_result"}, result, vecs[i].lo);
      check({vecs[i].name, "_result_hi"}, result_hi, vecs[i].hi);
      check({vecs[i].name, "_flags"}, W'({zero, cout, err_overflow, err_invalid_control}), W'(vecs[i].flags));
    end

`ifdef ALU_MULT_EN
    run_op(4'hD, 32'hFFFFFFFF, 32'h00000002, 5, lat, busy_n);
    check("multu_latency",   W'(lat), 32'd33);
    check("multu_busy",      W'(busy_n), 32'd33);
    check("multu_result",    result, 32'hFFFFFFFE);
    check("multu_result_hi", result_hi, 32'h00000001);
    check("multu_zero",      W'(zero), 32'd0);
    @(posedge clock); #1;
    check("multu_poke_ignored", W'(busy), 32'd0);
    check("multu_hold",      result, 32'hFFFFFFFE);
`endif

    // Abort a long op ten cycles in.
    @(negedge clock); #1;
    start = 1'b1;
`ifdef ALU_MULT_EN
    control = 4'hD; input_a = 32'h00000007; input_b = 32'h00000009;
`else
    control = 4'hA; input_a = 32'h80000000; input_b = 32'h0000001F;
`endif
    @(posedge clock); #1;
    start = 1'b0;
    repeat (9) @(posedge clock);
    #2;
    check("pre_reset_busy", W'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check("midop_reset_busy",     W'(busy), 32'd0);
    check("midop_reset_finished", W'(finished), 32'd0);
    check("midop_reset_result",   result, 32'd0);
    check("midop_reset_hi",       result_hi, 32'd0);
    check("midop_reset_flags",    W'({zero, cout, err_overflow, err_invalid_control}), 32'd0);
    @(negedge clock); #1;
    reset_n = 1'b1;

    run_op(4'h3, 32'd1, 32'd1, -1, lat, busy_n);
    check("post_reset_addu_latency", W'(lat), 32'd1);
    check("post_reset_addu_result",  result, 32'd2);
    check("post_reset_addu_flags",   W'({zero, cout, err_overflow, err_invalid_control}), 32'd0);

    repeat (2) @(posedge clock);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
